// File: rtl/signed_divider.sv
// Sequential signed divider: one restoring iteration per clock behind a start/done handshake.
// The quotient truncates toward zero and the remainder takes the dividend's sign.
module signed_divider #(
  parameter int BIT_WIDTH    = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [RESULT_WIDTH-1:0] dividend,
  input  logic signed [BIT_WIDTH-1:0]    divisor,
  output logic                           busy,
  output logic                           done,
  output logic signed [RESULT_WIDTH-1:0] quotient,
  output logic signed [BIT_WIDTH-1:0]    remainder,
  output logic                           div_by_zero,
  output logic                           overflow
);

  localparam int CW = $clog2(RESULT_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(RESULT_WIDTH - 1);
  localparam logic [RESULT_WIDTH-1:0] MOST_NEG = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    dz_pend;
  logic                    ovf_pend;
  logic                    q_neg, r_neg;
  logic [CW-1:0]           cnt;
  logic [BIT_WIDTH:0]      pr;
  logic [RESULT_WIDTH-1:0] dq;
  logic [BIT_WIDTH-1:0]    dvs_mag;
  logic [BIT_WIDTH+1:0]    shifted, diff;

  function automatic logic [RESULT_WIDTH-1:0] mag_q(input logic signed [RESULT_WIDTH-1:0] v);
    return v[RESULT_WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] mag_r(input logic signed [BIT_WIDTH-1:0] v);
    return v[BIT_WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [RESULT_WIDTH-1:0] neg_q(input logic [RESULT_WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] neg_r(input logic [BIT_WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // One extra headroom bit so a failed trial subtraction shows up as a set MSB.
  assign shifted = {pr, dq[RESULT_WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_mag};
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !dz_pend) begin
          accept = 1'b1;
          if (divisor != '0) state_nxt = CALC;
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      dz_pend <= accept && (divisor == '0);
      if (accept)             cnt <= '0;
      else if (state == CALC) cnt <= cnt + 1'b1;
      if (dz_pend) begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
        done        <= 1'b1;
      end else if (state == FIX) begin
        quotient    <= $signed(neg_q(dq, q_neg));
        remainder   <= $signed(neg_r(pr[BIT_WIDTH-1:0], r_neg));
        div_by_zero <= 1'b0;
        overflow    <= ovf_pend;
        done        <= 1'b1;
      end
    end
  end

  // Operand capture at acceptance, then one shift/subtract step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_neg    <= dividend[RESULT_WIDTH-1] ^ divisor[BIT_WIDTH-1];
      r_neg    <= dividend[RESULT_WIDTH-1];
      dq       <= mag_q(dividend);
      dvs_mag  <= mag_r(divisor);
      pr       <= '0;
      ovf_pend <= (dividend == MOST_NEG) && (divisor == '1);
    end else if (state == CALC) begin
      if (!diff[BIT_WIDTH+1]) begin
        pr <= diff[BIT_WIDTH:0];
        dq <= {dq[RESULT_WIDTH-2:0], 1'b1};
      end else begin
        pr <= shifted[BIT_WIDTH:0];
        dq <= {dq[RESULT_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
